fpga_config_loader: RTL and testbench
=====================================

# fpga_config_loader

Synthesizable successor to the file-driven configuration sequence for the `fpga` fabric. It accepts a bitstream as a narrow valid/ready word stream and packs it into `FRAME_W`-bit frames. Each frame is written into the fabric through `configs_in` with a one-cycle one-hot `configs_en` strobe. After the last frame it waits a settle interval, then raises `ff_en` and `rdy`. It sits between a bitstream source (host DMA, SPI bridge, ROM reader) and the `fpga` instance, and supports reconfiguration without reset.

## Interface
Parameters:
- `FRAME_W`, 384: width of one configuration frame (`configs_in`).
- `NUM_FRAMES`, 267: number of frames; width of `configs_en`.
- `IN_W`, 32: stream word width, 1..`FRAME_W`.
- `SETTLE_CYCLES`, 10: idle cycles between the last frame write and `ff_en` rising, ≥1.

Ports:
- `clock` in 1: sole clock, rising edge. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begins a load from frame 0.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word this cycle.
- `s_data` in `IN_W`: stream word.
- `configs_in` out `FRAME_W`: assembled frame, to fabric.
- `configs_en` out `NUM_FRAMES`: one-hot frame write strobe.
- `ff_en` out 1: fabric flip-flop enable.
- `rdy` out 1: configuration complete.
- `busy` out 1: high from `start` acceptance until `rdy` rises.

## Operation
- `BEATS = ceil(FRAME_W/IN_W)`. Words are packed LSB-first: word b fills `configs_in[b*IN_W +: IN_W]`. Bits of the last word above `FRAME_W` are discarded.
- States: IDLE, LOAD, WRITE, SETTLE, ENABLE, DONE.
- IDLE: `s_ready=0`. `start` → LOAD, with frame counter and beat counter cleared.
- LOAD: `s_ready=1`. A handshake (`s_valid&&s_ready`) writes the word into the frame shadow register and increments the beat counter. On the `BEATS`-th handshake → WRITE.
- WRITE: lasts exactly one cycle. `configs_en[frame]=1`, all other bits 0. `configs_in` already holds the complete frame, `s_ready=0`. Frame counter increments. If the frame was `NUM_FRAMES-1` → SETTLE, else → LOAD.
- SETTLE: counts `SETTLE_CYCLES` cycles, then → ENABLE.
- ENABLE: `ff_en=1` for one cycle, then → DONE.
- DONE: `ff_en=1`, `rdy=1`, held.
- `start` in DONE: reconfiguration. → LOAD; `ff_en` and `rdy` drop at that same edge.
- `start` in LOAD/WRITE/SETTLE/ENABLE is ignored.
- `configs_in` changes only on handshakes. It holds its value outside LOAD and is never partially updated during a WRITE strobe.
- `s_valid` low in LOAD stalls indefinitely. No timeout.
- Frame counter width is `$clog2(NUM_FRAMES)`. Beat counter width is `$clog2(BEATS)`, minimum 1. Neither counter wraps; both clear on entry to LOAD from IDLE or DONE.

## Timing
- Reset values: `s_ready=0`, `configs_in=0`, `configs_en=0`, `ff_en=0`, `rdy=0`, `busy=0`, state IDLE.
- `rst` at any point aborts a load: outputs return to reset values at the next edge and the partial bitstream is discarded.
- Registered outputs only. No combinational path from inputs to outputs, except that `s_ready` is a function of state alone.
- `start` sampled at edge t → LOAD at t+1, with `s_ready=1` and `busy=1` in that cycle.
- With `s_valid` held high, each frame takes `BEATS+1` cycles. Full load takes `NUM_FRAMES*(BEATS+1)` cycles.
- `ff_en` rises `SETTLE_CYCLES+1` cycles after the last WRITE cycle. `rdy` rises one cycle after `ff_en`. `busy` falls when `rdy` rises.

## Structure
- `fpga_cfg_pkg`: state enum `cfg_state_t`, default parameter constants, `BEATS` helper function.
- Sub-module `fpga_cfg_frame_asm`: beat counter plus shadow register, with a `frame_done` output. The FSM, frame counter, settle counter and one-hot decode stay in `fpga_config_loader`.

## Test plan
Parameters unless stated: `FRAME_W=40`, `IN_W=16`, `NUM_FRAMES=3`, `SETTLE_CYCLES=4` (BEATS=3).
- Nominal load: `start`, then words 0x1111, 0x2222, 0xFF33 (frame 0) with `s_valid` held high → `configs_en=3'b001` for one cycle with `configs_in=40'h33_2222_1111`. Frames 1 and 2 strobe `3'b010` and `3'b100`. `ff_en` rises 5 cycles after the last strobe, `rdy` 1 cycle later. Total 12 cycles from LOAD entry to the last strobe.
- Backpressure: random `s_valid` gaps of 0–5 cycles → identical frame contents and strobe order. `s_ready` is never high outside LOAD.
- Reset mid-load: assert `rst` during beat 2 of frame 1 → all outputs 0 next cycle. A subsequent `start` plus 9 words loads frame 0 first.
- Ignored start: `start` pulses during LOAD and SETTLE → no counter reset; strobe count stays 3.
- Reconfiguration: `start` in DONE → `ff_en` and `rdy` 0 at the next edge, `busy=1`, and a new load completes with the new data.
- Exact-fit width: `IN_W=40`, `BEATS=1` → one handshake per frame, 2 cycles per frame.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state type, default parameters and beat-count helper for the config loader.
package fpga_cfg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, SETTLE, ENABLE, DONE} cfg_state_t;
  localparam int DEF_FRAME_W = 384;
  localparam int DEF_NUM_FRAMES = 267;
  localparam int DEF_IN_W = 32;
  localparam int DEF_SETTLE_CYCLES = 10;
  function automatic int beats(input int frame_w, input int in_w);
    return (frame_w + in_w - 1) / in_w;
  endfunction
endpackage

// File: rtl/fpga_cfg_frame_asm.sv
// fpga_cfg_frame_asm: packs stream words LSB-first into a frame shadow register.
module fpga_cfg_frame_asm
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int IN_W = DEF_IN_W
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [IN_W-1:0]    data,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_done
);
  localparam int BEATS = beats(FRAME_W, IN_W);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [BW-1:0] beat;
  assign frame_done = we && beat == BW'(BEATS - 1);
  always_ff @(posedge clock)
    if (rst || clr || frame_done) beat <= '0;
    else if (we) beat <= beat + 1'b1;
  // The last beat may be narrower than a word; its surplus upper bits are dropped.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    localparam int LO = b * IN_W;
    localparam int W = (FRAME_W - LO < IN_W) ? FRAME_W - LO : IN_W;
    always_ff @(posedge clock)
      if (rst) frame[LO +: W] <= '0;
      else if (we && beat == BW'(b)) frame[LO +: W] <= data[W-1:0];
  end
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams a bitstream into fabric frames, then settles and enables flip-flops.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int IN_W = DEF_IN_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  output logic [FRAME_W-1:0]    configs_in,
  output logic [NUM_FRAMES-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy
);
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  cfg_state_t state, next;
  logic [FW-1:0] frame;
  logic [SW-1:0] settle;
  logic clr, hs, frame_done, last;
  assign s_ready = state == LOAD;
  assign hs = s_valid && s_ready;
  assign clr = start && (state == IDLE || state == DONE);
  assign last = frame == FW'(NUM_FRAMES - 1);
  fpga_cfg_frame_asm #(.FRAME_W(FRAME_W), .IN_W(IN_W)) u_asm (
    .clock(clock),
    .rst(rst),
    .clr(clr),
    .we(hs),
    .data(s_data),
    .frame(configs_in),
    .frame_done(frame_done)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: next = start ? LOAD : state;
      LOAD:       next = frame_done ? WRITE : LOAD;
      WRITE:      next = last ? SETTLE : LOAD;
      SETTLE:     next = settle == SW'(SETTLE_CYCLES - 1) ? ENABLE : SETTLE;
      ENABLE:     next = DONE;
      default:    next = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock)
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      settle <= '0;
      configs_en <= '0;
      ff_en <= 1'b0;
      rdy <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= next;
      frame <= clr ? '0 : (state == WRITE && !last) ? frame + 1'b1 : frame;
      settle <= (state == SETTLE && next == SETTLE) ? settle + 1'b1 : '0;
      configs_en <= next == WRITE ? NUM_FRAMES'(1) << frame : '0;
      ff_en <= next == ENABLE || next == DONE;
      rdy <= next == DONE;
      busy <= next inside {LOAD, WRITE, SETTLE, ENABLE};
    end
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: randomized checks of frame packing, strobes, timing and reconfiguration.
module tb_fpga_config_loader;
  localparam int FRW = 40;
  localparam int IW = 16;
  localparam int NF = 3;
  localparam int SC = 4;
  logic clock = 0, rst = 1, start = 0, s_valid = 0;
  logic [IW-1:0] s_data = '0;
  logic s_ready, ff_en, rdy, busy;
  logic [FRW-1:0] configs_in;
  logic [NF-1:0] configs_en;
  logic start2 = 0, s_valid2 = 0;
  logic [FRW-1:0] s_data2 = '0;
  logic s_ready2, ff_en2, rdy2, busy2;
  logic [FRW-1:0] configs_in2;
  logic [NF-1:0] configs_en2;
  fpga_config_loader #(.FRAME_W(FRW), .NUM_FRAMES(NF), .IN_W(IW), .SETTLE_CYCLES(SC)) dut (
    .clock(clock), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .configs_in(configs_in), .configs_en(configs_en), .ff_en(ff_en), .rdy(rdy), .busy(busy));
  fpga_config_loader #(.FRAME_W(FRW), .NUM_FRAMES(NF), .IN_W(FRW), .SETTLE_CYCLES(SC)) dut2 (
    .clock(clock), .rst(rst), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .configs_in(configs_in2), .configs_en(configs_en2), .ff_en(ff_en2), .rdy(rdy2), .busy(busy2));
  always #5 clock = ~clock;
  int cyc = 0, pass = 0, total = 0, timeouts = 0, load_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  logic [NF-1:0] obs_en[$], obs_en2[$];
  logic [FRW-1:0] obs_fr[$], obs_fr2[$];
  int obs_cyc[$], obs_cyc2[$];
  int ff_rise = -1, rdy_rise = -1, busy_fall = -1, sr_viol = 0;
  logic ff_p = 0, rdy_p = 0, busy_p = 0;
  logic [IW-1:0] words[$];
  always @(negedge clock) begin
    if (configs_en != 0) begin
      obs_en.push_back(configs_en);
      obs_fr.push_back(configs_in);
      obs_cyc.push_back(cyc);
    end
    if (configs_en2 != 0) begin
      obs_en2.push_back(configs_en2);
      obs_fr2.push_back(configs_in2);
      obs_cyc2.push_back(cyc);
    end
    if (ff_en && !ff_p) ff_rise = cyc;
    if (rdy && !rdy_p) rdy_rise = cyc;
    if (!busy && busy_p) busy_fall = cyc;
    if (s_ready && (configs_en != 0 || ff_en || rdy || !busy)) sr_viol++;
    ff_p = ff_en;
    rdy_p = rdy;
    busy_p = busy;
  end
  // Reference: frame f is words 3f..3f+2 laid side by side, lowest word in the lowest bits.
  function automatic logic [FRW-1:0] exp_frame(input int f);
    logic [63:0] v = '0;
    for (int b = 0; b < 3; b++) v += 64'(words[3*f+b]) << (IW * b);
    return v[FRW-1:0];
  endfunction
  task automatic gen_words(input bit nominal);
    words.delete();
    for (int i = 0; i < 9; i++) words.push_back(IW'($urandom));
    if (nominal) begin
      words[0] = 16'h1111;
      words[1] = 16'h2222;
      words[2] = 16'hFF33;
    end
  endtask
  task automatic clear_obs();
    obs_en.delete();
    obs_fr.delete();
    obs_cyc.delete();
    ff_rise = -1;
    rdy_rise = -1;
    busy_fall = -1;
    sr_viol = 0;
    timeouts = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clock);
    start = 0;
    load_cyc = cyc;
  endtask
  task automatic send(input logic [IW-1:0] w, input int gmax);
    int g = gmax > 0 ? int'($urandom_range(gmax, 0)) : 0;
    int n = 0;
    if (g > 0) begin
      s_valid = 0;
      repeat (g) @(negedge clock);
    end
    s_valid = 1;
    s_data = w;
    while (!s_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!s_ready) timeouts++;
    @(negedge clock);
  endtask
  task automatic send_range(input int lo, input int hi, input int gmax);
    for (int i = lo; i < hi; i++) send(words[i], gmax);
    s_valid = 0;
  endtask
  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!rdy) timeouts++;
    repeat (2) @(negedge clock);
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clock);
    total++;
    if ({s_ready, configs_in, configs_en, ff_en, rdy, busy} !== '0)
      $display("FAIL reset_outputs: got %0h want 0", {s_ready, configs_in, configs_en, ff_en, rdy, busy});
    else pass++;
    total++;
    if ({s_ready2, configs_in2, configs_en2, ff_en2, rdy2, busy2} !== '0)
      $display("FAIL reset_outputs2: got %0h want 0", {s_ready2, configs_in2, configs_en2, ff_en2, rdy2, busy2});
    else pass++;
    rst = 0;
    repeat (2) @(negedge clock);
  endtask
  task automatic test_nominal();
    gen_words(1);
    clear_obs();
    pulse_start();
    total++;
    if ({s_ready, busy} !== 2'b11) $display("FAIL start_ready_busy: got %b want 11", {s_ready, busy});
    else pass++;
    send_range(0, 9, 0);
    wait_rdy();
    total++;
    if (obs_en.size() !== 3) $display("FAIL nominal_count: got %0d want 3", obs_en.size());
    else pass++;
    for (int f = 0; f < 3; f++) begin
      total++;
      if (f >= obs_en.size()) $display("FAIL nominal_frame%0d: got none want en=%0h", f, 3'(1 << f));
      else if (obs_en[f] !== 3'(1 << f) || obs_fr[f] !== exp_frame(f))
        $display("FAIL nominal_frame%0d: got en=%0h data=%0h want en=%0h data=%0h", f, obs_en[f], obs_fr[f], 3'(1 << f), exp_frame(f));
      else pass++;
    end
    if (obs_en.size() == 3) begin
      total++;
      if (obs_fr[0] !== 40'h33_2222_1111) $display("FAIL nominal_literal: got %0h want 3322221111", obs_fr[0]);
      else pass++;
      total++;
      if (obs_cyc[2] - load_cyc !== 11) $display("FAIL nominal_load_cycles: got %0d want 11", obs_cyc[2] - load_cyc);
      else pass++;
      total++;
      if (ff_rise - obs_cyc[2] !== SC + 1) $display("FAIL nominal_ff_en_delay: got %0d want %0d", ff_rise - obs_cyc[2], SC + 1);
      else pass++;
    end
    total++;
    if (rdy_rise - ff_rise !== 1 || busy_fall !== rdy_rise)
      $display("FAIL nominal_rdy_busy: got rdy-ff=%0d busy_fall=%0d want 1 and %0d", rdy_rise - ff_rise, busy_fall, rdy_rise);
    else pass++;
    total++;
    if (sr_viol !== 0 || timeouts !== 0) $display("FAIL nominal_ready_misuse: got %0d/%0d want 0/0", sr_viol, timeouts);
    else pass++;
  endtask
  task automatic test_backpressure();
    for (int it = 0; it < 2; it++) begin
      gen_words(0);
      clear_obs();
      pulse_start();
      send_range(0, 9, 5);
      wait_rdy();
      for (int f = 0; f < 3; f++) begin
        total++;
        if (f >= obs_en.size()) $display("FAIL bp%0d_frame%0d: got none want en=%0h", it, f, 3'(1 << f));
        else if (obs_en[f] !== 3'(1 << f) || obs_fr[f] !== exp_frame(f))
          $display("FAIL bp%0d_frame%0d: got en=%0h data=%0h want en=%0h data=%0h", it, f, obs_en[f], obs_fr[f], 3'(1 << f), exp_frame(f));
        else pass++;
      end
      total++;
      if (obs_en.size() !== 3 || sr_viol !== 0 || timeouts !== 0)
        $display("FAIL bp%0d_misc: got n=%0d viol=%0d to=%0d want 3/0/0", it, obs_en.size(), sr_viol, timeouts);
      else pass++;
    end
  endtask
  task automatic test_reconfig();
    total++;
    if ({ff_en, rdy, busy} !== 3'b110) $display("FAIL reconfig_done_state: got %b want 110", {ff_en, rdy, busy});
    else pass++;
    gen_words(0);
    clear_obs();
    pulse_start();
    total++;
    if ({ff_en, rdy, busy, s_ready} !== 4'b0011) $display("FAIL reconfig_drop: got %b want 0011", {ff_en, rdy, busy, s_ready});
    else pass++;
    send_range(0, 9, 1);
    wait_rdy();
    for (int f = 0; f < 3; f++) begin
      total++;
      if (f >= obs_en.size()) $display("FAIL reconfig_frame%0d: got none want en=%0h", f, 3'(1 << f));
      else if (obs_en[f] !== 3'(1 << f) || obs_fr[f] !== exp_frame(f))
        $display("FAIL reconfig_frame%0d: got en=%0h data=%0h want en=%0h data=%0h", f, obs_en[f], obs_fr[f], 3'(1 << f), exp_frame(f));
      else pass++;
    end
    total++;
    if ({ff_en, rdy, busy} !== 3'b110) $display("FAIL reconfig_complete: got %b want 110", {ff_en, rdy, busy});
    else pass++;
  endtask
  task automatic test_reset_midload();
    gen_words(0);
    clear_obs();
    pulse_start();
    send_range(0, 5, 0);
    s_valid = 1;
    rst = 1;
    @(negedge clock);
    total++;
    if ({s_ready, configs_in, configs_en, ff_en, rdy, busy} !== '0)
      $display("FAIL midload_reset: got %0h want 0", {s_ready, configs_in, configs_en, ff_en, rdy, busy});
    else pass++;
    total++;
    if (obs_en.size() !== 1) $display("FAIL midload_strobes_before: got %0d want 1", obs_en.size());
    else pass++;
    rst = 0;
    s_valid = 0;
    repeat (2) @(negedge clock);
    gen_words(0);
    clear_obs();
    pulse_start();
    send_range(0, 9, 2);
    wait_rdy();
    for (int f = 0; f < 3; f++) begin
      total++;
      if (f >= obs_en.size()) $display("FAIL midload_frame%0d: got none want en=%0h", f, 3'(1 << f));
      else if (obs_en[f] !== 3'(1 << f) || obs_fr[f] !== exp_frame(f))
        $display("FAIL midload_frame%0d: got en=%0h data=%0h want en=%0h data=%0h", f, obs_en[f], obs_fr[f], 3'(1 << f), exp_frame(f));
      else pass++;
    end
  endtask
  task automatic test_ignored_start();
    gen_words(0);
    clear_obs();
    pulse_start();
    send_range(0, 4, 0);
    pulse_start();
    send_range(4, 9, 0);
    @(negedge clock);
    pulse_start();
    wait_rdy();
    total++;
    if (obs_en.size() !== 3) $display("FAIL ignored_count: got %0d want 3", obs_en.size());
    else pass++;
    for (int f = 0; f < 3; f++) begin
      total++;
      if (f >= obs_en.size()) $display("FAIL ignored_frame%0d: got none want en=%0h", f, 3'(1 << f));
      else if (obs_en[f] !== 3'(1 << f) || obs_fr[f] !== exp_frame(f))
        $display("FAIL ignored_frame%0d: got en=%0h data=%0h want en=%0h data=%0h", f, obs_en[f], obs_fr[f], 3'(1 << f), exp_frame(f));
      else pass++;
    end
    if (obs_en.size() == 3) begin
      total++;
      if (ff_rise - obs_cyc[2] !== SC + 1) $display("FAIL ignored_settle: got %0d want %0d", ff_rise - obs_cyc[2], SC + 1);
      else pass++;
    end
  endtask
  task automatic test_exact_fit();
    logic [FRW-1:0] w[3];
    int k, n;
    for (int i = 0; i < 3; i++) w[i] = {8'($urandom), 32'($urandom)};
    obs_en2.delete();
    obs_fr2.delete();
    obs_cyc2.delete();
    start2 = 1;
    @(negedge clock);
    start2 = 0;
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      s_valid2 = 1;
      s_data2 = w[i];
      while (!s_ready2 && n < 50) begin
        @(negedge clock);
        n++;
      end
      @(negedge clock);
    end
    s_valid2 = 0;
    n = 0;
    while (!rdy2 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    total++;
    if (obs_en2.size() !== 3) $display("FAIL exact_count: got %0d want 3", obs_en2.size());
    else pass++;
    for (int f = 0; f < 3; f++) begin
      total++;
      if (f >= obs_en2.size()) $display("FAIL exact_frame%0d: got none want en=%0h", f, 3'(1 << f));
      else if (obs_en2[f] !== 3'(1 << f) || obs_fr2[f] !== w[f] || obs_cyc2[f] - k !== 2 * f + 1)
        $display("FAIL exact_frame%0d: got en=%0h data=%0h at %0d want en=%0h data=%0h at %0d", f, obs_en2[f], obs_fr2[f], obs_cyc2[f] - k, 3'(1 << f), w[f], 2 * f + 1);
      else pass++;
    end
    total++;
    if ({ff_en2, rdy2, busy2} !== 3'b110) $display("FAIL exact_complete: got %b want 110", {ff_en2, rdy2, busy2});
    else pass++;
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_reconfig();
    test_reset_midload();
    test_ignored_start();
    test_exact_fit();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
